mem_port_arbiter: RTL and testbench

//  Shares the single word-granular external memory port between the instruction

---
 rtl/mem_port_arbiter_if.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Purpose : bundles the two cache request ports and the external memory port
//           seen by mem_port_arbiter.
// Latency : n/a (signal bundle only).
// Backpressure: n/a; the arbiter drives o_pN_ready from i_mem_ready and FIFO space.
// Ports (arbiter view, modport slave):
//   i_pN_addr/ren/wen/wdata  in   cache port N request (N=0 icache, N=1 dcache)
//   o_pN_ready/rdata/valid   out  port N accept strobe and read return
//   i_mem_ready/rdata/valid  in   memory accept strobe and in-order read return
//   o_mem_addr/ren/wen/wdata out  granted request towards memory
//   o_rsp_err                out  sticky unexpected-response flag
// The master modport is the environment view (caches plus memory model).
interface mem_port_arbiter_if;
  logic [31:0] i_p0_addr;
  logic        i_p0_ren;
  logic        i_p0_wen;
  logic [31:0] i_p0_wdata;
  logic        o_p0_ready;
  logic [31:0] o_p0_rdata;
  logic        o_p0_valid;

  logic [31:0] i_p1_addr;
  logic        i_p1_ren;
  logic        i_p1_wen;
  logic [31:0] i_p1_wdata;
  logic        o_p1_ready;
  logic [31:0] o_p1_rdata;
  logic        o_p1_valid;

  logic        i_mem_ready;
  logic [31:0] o_mem_addr;
  logic        o_mem_ren;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
  logic        i_mem_valid;
  logic        o_rsp_err;

  modport slave (
    input  i_p0_addr, i_p0_ren, i_p0_wen, i_p0_wdata,
    output o_p0_ready, o_p0_rdata, o_p0_valid,
    input  i_p1_addr, i_p1_ren, i_p1_wen, i_p1_wdata,
    output o_p1_ready, o_p1_rdata, o_p1_valid,
    input  i_mem_ready, i_mem_rdata, i_mem_valid,
    output o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_rsp_err
  );

  modport master (
    output i_p0_addr, i_p0_ren, i_p0_wen, i_p0_wdata,
    input  o_p0_ready, o_p0_rdata, o_p0_valid,
    output i_p1_addr, i_p1_ren, i_p1_wen, i_p1_wdata,
    input  o_p1_ready, o_p1_rdata, o_p1_valid,
    output i_mem_ready, i_mem_rdata, i_mem_valid,
    input  o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_rsp_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one word-granular memory port between icache (port 0) and
//           dcache (port 1); round-robin grant, in-order read ID tracking.
// Latency : zero added cycles on issue; read data routed combinationally.
// Backpressure: a port stalls (ready=0) when i_mem_ready=0, when it loses
//           arbitration, or for reads when DEPTH reads are already in flight.
// Ports   : i_clk clock; i_rst async active-high reset; bus = mem_port_arbiter_if.slave.
// Config  : define ARB_DCACHE_PRIO_EN for fixed priority (dcache always wins).
module mem_port_arbiter #(
  parameter int DEPTH = 4
) (
  input logic               i_clk,
  input logic               i_rst,
  mem_port_arbiter_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ID FIFO: one bit per in-flight read, set = dcache issued it.
  logic [DEPTH-1:0] id_q,    id_d;
  logic [PW-1:0]    head_q,  head_d;
  logic [PW-1:0]    tail_q,  tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rsp_err_q, rsp_err_d;

  logic p0_elig, p1_elig;
  logic both_pick;
  logic gnt_vld, gnt_p1;
  logic push, pop, head_p1;

  // Read eligibility uses the registered count only: a response popping in
  // the same cycle does not free a slot until the next cycle.
  logic space_ok;
  assign space_ok = (count_q < CW'(DEPTH));
  assign p0_elig  = bus.i_mem_ready & (bus.i_p0_wen | (bus.i_p0_ren & space_ok));
  assign p1_elig  = bus.i_mem_ready & (bus.i_p1_wen | (bus.i_p1_ren & space_ok));

`ifdef ARB_DCACHE_PRIO_EN
  assign both_pick = 1'b1;
`else
  logic last_grant_q, last_grant_d;

  assign both_pick = ~last_grant_q;

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt_vld) last_grant_d = gnt_p1;
  end

  // Reset to 1 so that port 0 wins the first contended cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end
`endif

  always_comb begin
    gnt_vld = p0_elig | p1_elig;
    gnt_p1  = p1_elig;
    if (p0_elig && p1_elig) gnt_p1 = both_pick;
  end

  // Memory side: idle cycles drive zeros rather than a stale requester.
  assign bus.o_mem_ren   = gnt_vld & (gnt_p1 ? bus.i_p1_ren : bus.i_p0_ren);
  assign bus.o_mem_wen   = gnt_vld & (gnt_p1 ? bus.i_p1_wen : bus.i_p0_wen);
  assign bus.o_mem_addr  = !gnt_vld ? '0 : (gnt_p1 ? bus.i_p1_addr  : bus.i_p0_addr);
  assign bus.o_mem_wdata = !gnt_vld ? '0 : (gnt_p1 ? bus.i_p1_wdata : bus.i_p0_wdata);
  assign bus.o_p0_ready  = gnt_vld & ~gnt_p1;
  assign bus.o_p1_ready  = gnt_vld &  gnt_p1;

  // A response with nothing in flight is dropped; memory latency is >= 1 so a
  // read issued this same cycle cannot be the one answering.
  assign push    = bus.o_mem_ren;
  assign pop     = bus.i_mem_valid & (count_q != '0);
  assign head_p1 = id_q[head_q];

  assign bus.o_p0_valid = pop & ~head_p1;
  assign bus.o_p1_valid = pop &  head_p1;
  assign bus.o_p0_rdata = bus.i_mem_rdata;
  assign bus.o_p1_rdata = bus.i_mem_rdata;
  assign bus.o_rsp_err  = rsp_err_q;

  always_comb begin
    id_d      = id_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    rsp_err_d = rsp_err_q;
    if (push) begin
      id_d[tail_q] = gnt_p1;
      tail_d       = ptr_inc(tail_q);
    end
    if (pop) head_d = ptr_inc(head_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (bus.i_mem_valid && count_q == '0) rsp_err_d = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      id_q      <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      id_q      <= id_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rsp_err_q <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : self-checking bench for mem_port_arbiter (directed steps + random traffic).
// Latency : inputs applied after the falling edge, outputs checked 1ns later.
// Backpressure: requesters hold a request until the model grants it.
module tb_mem_port_arbiter;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: ports of in-flight reads in issue order.
  int q[$];
  int last_g = 1;
  bit m_err  = 1'b0;
  int mgnt   = -1;   // model grant of the last cycle (-1 none)
  int obs_g  = -1;   // DUT grant seen on ready lines in the last cycle

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                        input logic mrdy, input logic mval, input logic [31:0] mrd);
    bus.i_p0_ren = r0; bus.i_p0_wen = w0; bus.i_p0_addr = a0; bus.i_p0_wdata = d0;
    bus.i_p1_ren = r1; bus.i_p1_wen = w1; bus.i_p1_addr = a1; bus.i_p1_wdata = d1;
    bus.i_mem_ready = mrdy; bus.i_mem_valid = mval; bus.i_mem_rdata = mrd;
  endtask

  // One clock cycle: drive, predict, compare, then advance the model.
  task automatic cyc(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                     input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                     input logic mrdy, input logic mval, input logic [31:0] mrd);
    bit e0, e1, pop, en_r, en_w;
    int g, hd, inflight;
    logic [31:0] ea, ed;
    set_in(r0, w0, a0, d0, r1, w1, a1, d1, mrdy, mval, mrd);
    #1;
    inflight = q.size();
    e0 = mrdy && (w0 || (r0 && inflight < DEPTH));
    e1 = mrdy && (w1 || (r1 && inflight < DEPTH));
    g = -1;
    if (e0 && e1) begin
`ifdef ARB_DCACHE_PRIO_EN
      g = 1;
`else
      g = (last_g == 0) ? 1 : 0;
`endif
    end else if (e0) g = 0;
    else if (e1) g = 1;
    en_r = (g == 0) ? r0 : (g == 1) ? r1 : 1'b0;
    en_w = (g == 0) ? w0 : (g == 1) ? w1 : 1'b0;
    ea   = (g == 0) ? a0 : (g == 1) ? a1 : 32'h0;
    ed   = (g == 0) ? d0 : (g == 1) ? d1 : 32'h0;
    pop  = mval && inflight > 0;
    hd   = pop ? q[0] : -1;

    chk("mem_ren",   bus.o_mem_ren,   en_r);
    chk("mem_wen",   bus.o_mem_wen,   en_w);
    chk("mem_addr",  bus.o_mem_addr,  ea);
    chk("mem_wdata", bus.o_mem_wdata, ed);
    chk("p0_ready",  bus.o_p0_ready,  g == 0);
    chk("p1_ready",  bus.o_p1_ready,  g == 1);
    chk("p0_valid",  bus.o_p0_valid,  hd == 0);
    chk("p1_valid",  bus.o_p1_valid,  hd == 1);
    chk("p0_rdata",  bus.o_p0_rdata,  mrd);
    chk("p1_rdata",  bus.o_p1_rdata,  mrd);
    chk("rsp_err",   bus.o_rsp_err,   m_err);

    obs_g = bus.o_p1_ready ? 1 : (bus.o_p0_ready ? 0 : -1);
    mgnt  = g;
    if (pop) void'(q.pop_front());
    if (en_r) q.push_back(g);
    if (g >= 0) last_g = g;
    if (mval && inflight == 0) m_err = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input logic mval, input logic [31:0] mrd);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1'b1, mval, mrd);
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("rst_mem_ren",  bus.o_mem_ren,  1'b0);
    chk("rst_mem_addr", bus.o_mem_addr, 32'h0);
    chk("rst_rsp_err",  bus.o_rsp_err,  1'b0);
    chk("rst_ready",    {bus.o_p0_ready, bus.o_p1_ready}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    last_g = 1;
    m_err  = 1'b0;
  endtask

  // Random requester state
  bit          pv[2];
  bit          pr[2];
  logic [31:0] pa[2];
  logic [31:0] pd[2];

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    do_reset();

    // Single icache read, answered three cycles later.
    cyc(1, 0, 32'h100, 0, 0, 0, 0, 0, 1'b1, 1'b0, 32'h0);
    chk("t1_grant", obs_g, 0);
    idle(0, 0);
    idle(0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 32'hDEADBEEF);
    chk("t1_fifo_empty", q.size(), 0);

    // Both ports read every cycle for four cycles.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 32'h1000 + i, 0, 1, 0, 32'h2000 + i, 0, 1'b1, 1'b0, 32'h0);
`ifdef ARB_DCACHE_PRIO_EN
      chk("t2_grant", obs_g, 1);
`else
      chk("t2_grant", obs_g, i % 2);
`endif
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 32'hAAAA0001);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 32'hBBBB0002);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 32'hCCCC0003);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 32'hDDDD0004);

    // FIFO full: further reads stall while writes still pass.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 32'h300 + i, 0, 0, 0, 0, 0, 1'b1, 1'b0, 0);
    cyc(1, 0, 32'h400, 0, 0, 1, 32'h200, 32'h55, 1'b1, 1'b0, 0);
    chk("t3_write_gnt", obs_g, 1);
    cyc(1, 0, 32'h400, 0, 0, 0, 0, 0, 1'b1, 1'b0, 0);
    chk("t3_read_stall", obs_g, -1);
    cyc(1, 0, 32'h400, 0, 0, 0, 0, 0, 1'b1, 1'b1, 32'h12345678);
    chk("t3_no_pop_bypass", obs_g, -1);
    cyc(1, 0, 32'h400, 0, 0, 0, 0, 0, 1'b1, 1'b0, 0);
    chk("t3_read_after_pop", obs_g, 0);

    // Memory not ready: nothing moves.
    cyc(1, 0, 32'h500, 0, 1, 0, 32'h600, 0, 1'b0, 1'b0, 0);
    chk("t4_stall", obs_g, -1);
    for (int i = 0; i < DEPTH; i++) idle(1, 32'h700 + i);

    // Stray response with empty FIFO sets the sticky error.
    idle(1, 32'hBAD0BAD0);
    idle(0, 0);
    chk("t5_err_set", bus.o_rsp_err, 1'b1);
    idle(0, 0);
    do_reset();
    chk("t5_err_clr", bus.o_rsp_err, 1'b0);

    // Random traffic with in-order memory responses of random latency.
    pv[0] = 0; pv[1] = 0;
    for (int c = 0; c < 400; c++) begin
      bit mrdy, mval;
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && $urandom_range(0, 1) == 1) begin
          pv[p] = 1;
          pr[p] = ($urandom_range(0, 2) != 0);
          pa[p] = $urandom;
          pd[p] = $urandom;
        end
      end
      mrdy = ($urandom_range(0, 3) != 0);
      mval = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      cyc(pv[0] & pr[0], pv[0] & ~pr[0], pa[0], pd[0],
          pv[1] & pr[1], pv[1] & ~pr[1], pa[1], pd[1],
          mrdy, mval, $urandom);
      if (mgnt >= 0) pv[mgnt] = 0;
    end
    chk("rand_no_err", bus.o_rsp_err, 1'b0);

`ifdef ARB_DCACHE_PRIO_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 32'h10 + i, 0, 1, 0, 32'h20 + i, 0, 1'b1, 1'b0, 0);
      chk("prio_grant", obs_g, 1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
